// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore main FSM, ALU decoder and PC-enable logic.
// Write strobes are gated by reset so an interrupted instruction cannot commit anything.
module mips_multicycle_controller #(
   parameter int unsigned STATE_W = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   output logic       iord_o,
   output logic       memwrite_o,
   output logic       irwrite_o,
   output logic       regdst_o,
   output logic       memtoreg_o,
   output logic       regwrite_o,
   output logic       alusrca_o,
   output logic [1:0] alusrcb_o,
   output logic [1:0] pcsrc_o,
   output logic [2:0] alucontrol_o,
   output logic       pcen_o
);

   typedef enum logic [STATE_W-1:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StRtypeEx = 4'd6,
      StRtypeWb = 4'd7,
      StBeqEx   = 4'd8,
      StAddiEx  = 4'd9,
      StAddiWb  = 4'd10,
      StJEx     = 4'd11,
      StBneEx   = 4'd12
   } state_e;

   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   state_e     state_q, state_d;
   logic       pcwrite, branch, branchne;
   logic [1:0] aluop;
   logic       memwrite_raw, regwrite_raw, irwrite_raw;

   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:   state_d = StDecode;
         StDecode: begin
            case (op_i)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StRtypeEx;
               OpBeq:      state_d = StBeqEx;
               OpBne:      state_d = StBneEx;
               OpAddi:     state_d = StAddiEx;
               OpJ:        state_d = StJEx;
               default:    state_d = StFetch;
            endcase
         end
         StMemAdr:  state_d = (op_i == OpLw) ? StMemRd : StMemWr;
         StMemRd:   state_d = StMemWb;
         StRtypeEx: state_d = StRtypeWb;
         StAddiEx:  state_d = StAddiWb;
         default:   state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      iord_o       = 1'b0;
      memwrite_raw = 1'b0;
      irwrite_raw  = 1'b0;
      regdst_o     = 1'b0;
      memtoreg_o   = 1'b0;
      regwrite_raw = 1'b0;
      alusrca_o    = 1'b0;
      alusrcb_o    = 2'b00;
      pcsrc_o      = 2'b00;
      aluop        = 2'b00;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      branchne     = 1'b0;
      case (state_q)
         StFetch: begin
            irwrite_raw = 1'b1;
            alusrcb_o   = 2'b01;
            pcwrite     = 1'b1;
         end
         StDecode: alusrcb_o = 2'b11;
         StMemAdr, StAddiEx: begin
            alusrca_o = 1'b1;
            alusrcb_o = 2'b10;
         end
         StMemRd: iord_o = 1'b1;
         StMemWb: begin
            memtoreg_o   = 1'b1;
            regwrite_raw = 1'b1;
         end
         StMemWr: begin
            iord_o       = 1'b1;
            memwrite_raw = 1'b1;
         end
         StRtypeEx: begin
            alusrca_o = 1'b1;
            aluop     = 2'b10;
         end
         StRtypeWb: begin
            regdst_o     = 1'b1;
            regwrite_raw = 1'b1;
         end
         StBeqEx, StBneEx: begin
            alusrca_o = 1'b1;
            aluop     = 2'b01;
            pcsrc_o   = 2'b01;
            branch    = (state_q == StBeqEx);
            branchne  = (state_q == StBneEx);
         end
         StAddiWb: regwrite_raw = 1'b1;
         StJEx: begin
            pcsrc_o = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      alucontrol_o = 3'b010;
      case (aluop)
         2'b01: alucontrol_o = 3'b110;
         2'b10: begin
            case (funct_i)
               6'b100010: alucontrol_o = 3'b110;
               6'b100100: alucontrol_o = 3'b000;
               6'b100101: alucontrol_o = 3'b001;
               6'b101010: alucontrol_o = 3'b111;
               default:   alucontrol_o = 3'b010;
            endcase
         end
         default: alucontrol_o = 3'b010;
      endcase
   end

   // Branch enable follows zero combinationally within the execute cycle.
   assign memwrite_o = memwrite_raw & ~reset_i;
   assign regwrite_o = regwrite_raw & ~reset_i;
   assign irwrite_o  = irwrite_raw & ~reset_i;
   assign pcen_o     = (pcwrite | (branch & zero_i) | (branchne & ~zero_i)) & ~reset_i;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomized bench: an instruction-level model predicts every control output each cycle,
// with a few literal checks around reset release.
module tb_mips_multicycle_controller;

   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] alucontrol;
      logic       pcen;
   } ctrl_t;

   localparam int CLw = 0, CSw = 1, CR = 2, CAddi = 3, CBeq = 4, CBne = 5, CJ = 6, CNop = 7;

   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic [5:0] op_i = 6'b111111;
   logic [5:0] funct_i = 6'b0;
   logic       zero_i = 1'b0;
   logic       iord_o, memwrite_o, irwrite_o, regdst_o, memtoreg_o, regwrite_o, alusrca_o;
   logic [1:0] alusrcb_o, pcsrc_o;
   logic [2:0] alucontrol_o;
   logic       pcen_o;

   int checks = 0;
   int errors = 0;
   bit model_valid = 1'b0;
   int cls = CNop;
   int step = 0;

   always #5 clk = ~clk;

   mips_multicycle_controller #(.STATE_W(4)) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .op_i        (op_i),
      .funct_i     (funct_i),
      .zero_i      (zero_i),
      .iord_o      (iord_o),
      .memwrite_o  (memwrite_o),
      .irwrite_o   (irwrite_o),
      .regdst_o    (regdst_o),
      .memtoreg_o  (memtoreg_o),
      .regwrite_o  (regwrite_o),
      .alusrca_o   (alusrca_o),
      .alusrcb_o   (alusrcb_o),
      .pcsrc_o     (pcsrc_o),
      .alucontrol_o(alucontrol_o),
      .pcen_o      (pcen_o)
   );

   function automatic int classify(input logic [5:0] op);
      case (op)
         6'b100011: return CLw;
         6'b101011: return CSw;
         6'b000000: return CR;
         6'b001000: return CAddi;
         6'b000100: return CBeq;
         6'b000101: return CBne;
         6'b000010: return CJ;
         default:   return CNop;
      endcase
   endfunction

   function automatic int instr_len(input int c);
      case (c)
         CLw:                      return 5;
         CSw, CR, CAddi:           return 4;
         CBeq, CBne, CJ:           return 3;
         default:                  return 2;
      endcase
   endfunction

   // Expected controls for cycle 'st' (0 = fetch) of an instruction of class 'c'.
   function automatic ctrl_t expect_ctrl(input int c, input int st, input logic [5:0] f,
                                         input logic z, input logic rst);
      ctrl_t e = '0;
      e.alucontrol = 3'b010;
      if (st == 0) begin
         e.irwrite = 1'b1; e.alusrcb = 2'b01; e.pcen = 1'b1;
      end else if (st == 1) begin
         e.alusrcb = 2'b11;
      end else begin
         case (c)
            CLw, CSw, CAddi: begin
               if (st == 2) begin
                  e.alusrca = 1'b1; e.alusrcb = 2'b10;
               end else if (c == CLw && st == 3) begin
                  e.iord = 1'b1;
               end else if (c == CLw) begin
                  e.memtoreg = 1'b1; e.regwrite = 1'b1;
               end else if (c == CSw) begin
                  e.iord = 1'b1; e.memwrite = 1'b1;
               end else begin
                  e.regwrite = 1'b1;
               end
            end
            CR: begin
               if (st == 2) begin
                  e.alusrca = 1'b1;
                  case (f)
                     6'b100010: e.alucontrol = 3'b110;
                     6'b100100: e.alucontrol = 3'b000;
                     6'b100101: e.alucontrol = 3'b001;
                     6'b101010: e.alucontrol = 3'b111;
                     default:   e.alucontrol = 3'b010;
                  endcase
               end else begin
                  e.regdst = 1'b1; e.regwrite = 1'b1;
               end
            end
            CBeq, CBne: begin
               e.alusrca = 1'b1; e.pcsrc = 2'b01; e.alucontrol = 3'b110;
               e.pcen = (c == CBeq) ? z : ~z;
            end
            CJ: begin
               e.pcsrc = 2'b10; e.pcen = 1'b1;
            end
            default: ;
         endcase
      end
      if (rst) begin
         e.memwrite = 1'b0; e.regwrite = 1'b0; e.irwrite = 1'b0; e.pcen = 1'b0;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (model_valid) begin
         ctrl_t got, exp;
         got = '{iord_o, memwrite_o, irwrite_o, regdst_o, memtoreg_o, regwrite_o, alusrca_o,
                 alusrcb_o, pcsrc_o, alucontrol_o, pcen_o};
         exp = expect_ctrl(cls, step, funct_i, zero_i, reset_i);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL ctrl cls=%0d step=%0d op=%b funct=%b zero=%b rst=%b got=%h want=%h",
                     cls, step, op_i, funct_i, zero_i, reset_i, got, exp);
         end
      end
   end

   task automatic lit(input string name, input logic [2:0] got, input logic [2:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%b want=%b", name, got, want);
      end
   endtask

   task automatic advance(input logic rst);
      @(posedge clk);
      #1;
      if (rst) begin
         step = 0;
         model_valid = 1'b1;
      end else begin
         step = (step + 1 == instr_len(cls)) ? 0 : step + 1;
      end
   endtask

   // zmode: 0/1 force zero, 2 random. abort_step < 0 means no mid-instruction reset.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode,
                            input int abort_step);
      op_i = op;
      funct_i = f;
      cls = classify(op);
      for (int s = 0; s < instr_len(cls); s++) begin
         reset_i = (s == abort_step);
         zero_i = (zmode == 2) ? 1'($urandom) : 1'(zmode);
         advance(reset_i);
         if (s == abort_step) begin
            reset_i = 1'b0;
            break;
         end
      end
   endtask

   logic [5:0] ops [7];
   logic [5:0] functs [6];

   initial begin
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000101, 6'b000010};
      functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
      @(negedge clk);
      #1;
      lit("rst_memwrite", {2'b0, memwrite_o}, 3'b0);
      lit("rst_regwrite", {2'b0, regwrite_o}, 3'b0);
      lit("rst_irwrite_pcen", {1'b0, irwrite_o, pcen_o}, 3'b0);
      advance(1'b1);
      advance(1'b1);
      reset_i = 1'b0;
      op_i = 6'b111111;
      cls = CNop;
      @(negedge clk);
      #1;
      lit("fetch_irwrite_pcen", {1'b0, irwrite_o, pcen_o}, 3'b011);
      lit("fetch_alusrcb", {1'b0, alusrcb_o}, 3'b001);
      lit("fetch_alucontrol", alucontrol_o, 3'b010);
      advance(1'b0);
      @(negedge clk);
      #1;
      lit("decode_alusrcb", {1'b0, alusrcb_o}, 3'b011);
      lit("decode_writes", {memwrite_o, regwrite_o, irwrite_o}, 3'b000);
      advance(1'b0);

      run_instr(6'b100011, 6'b0, 2, -1);
      run_instr(6'b101011, 6'b0, 2, -1);
      run_instr(6'b101011, 6'b0, 2, 3);
      foreach (functs[i]) run_instr(6'b000000, functs[i], 2, -1);
      run_instr(6'b000100, 6'b0, 1, -1);
      run_instr(6'b000100, 6'b0, 0, -1);
      run_instr(6'b000101, 6'b0, 0, -1);
      run_instr(6'b000101, 6'b0, 1, -1);
      run_instr(6'b000010, 6'b0, 2, -1);
      run_instr(6'b111111, 6'b0, 2, -1);
      run_instr(6'b001000, 6'b0, 2, -1);

      repeat (300) begin
         logic [5:0] op, f;
         int ab;
         op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
         f = ($urandom_range(0, 2) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
         ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, instr_len(classify(op)) - 1) : -1;
         run_instr(op, f, 2, ab);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
